trax_tile_placer: RTL and testbench

//  Fetch side and commit side of the tile-check interface. Accepts a board position, reads the centre

---
 rtl/trax_tile_placer_if.sv | 38 +++
 rtl/trax_tile_placer.sv | 182 ++++++++++++++++++
 tb/tb_trax_tile_placer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trax_tile_placer_if.sv
// rtl/trax_tile_placer_if.sv - move-controller, board RAM and tile_check signal bundle for the tile placer
interface trax_tile_placer_if #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
);
  logic                         req_valid;
  logic                         req_ready;
  logic [ROW_BITS-1:0]          req_row;
  logic [COL_BITS-1:0]          req_col;
  logic [ROW_BITS+COL_BITS-1:0] mem_addr;
  logic                         mem_rd_en;
  logic                         mem_wr_en;
  logic [2:0]                   mem_wdata;
  logic [2:0]                   mem_rdata;
  logic                         chk_start;
  logic [2:0]                   chk_up;
  logic [2:0]                   chk_down;
  logic [2:0]                   chk_left;
  logic [2:0]                   chk_right;
  logic [5:0]                   chk_tile_type;
  logic                         chk_done;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [2:0]                   rsp_tile;
  logic [2:0]                   rsp_status;

  modport master (
    input  req_valid, req_row, req_col, mem_rdata, chk_tile_type, chk_done, rsp_ready,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, chk_start,
           chk_up, chk_down, chk_left, chk_right, rsp_valid, rsp_tile, rsp_status
  );

  modport slave (
    output req_valid, req_row, req_col, mem_rdata, chk_tile_type, chk_done, rsp_ready,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, chk_start,
           chk_up, chk_down, chk_left, chk_right, rsp_valid, rsp_tile, rsp_status
  );
endinterface

// File: rtl/trax_tile_placer.sv
// rtl/trax_tile_placer.sv - reads a cell and its neighbours, runs tile_check, commits a forced tile
module trax_tile_placer #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3,
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  trax_tile_placer_if.master   bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS + 1)'(ROWS);
  localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS + 1)'(COLS);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] ST_PLACED   = 3'd0;
  localparam logic [2:0] ST_OCCUPIED = 3'd1;
  localparam logic [2:0] ST_MULTI    = 3'd2;
  localparam logic [2:0] ST_NONE     = 3'd3;
  localparam logic [2:0] ST_BADPOS   = 3'd4;

  typedef enum logic [3:0] {IDLE, RD_C, RD_U, RD_D, RD_L, RD_R, CAP_R, WAIT, WRITE, RESP} state_t;

  state_t              state;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                rd_q;
  logic                rd_prev;
  logic [CW-1:0]       cnt;
  logic [2:0]          low_code;
  logic [2:0]          cap;
  logic                one_hot;
  logic                bad_pos;

  // The up read shares RD_U with the centre check, so an occupied centre cancels it here.
  assign bus.mem_rd_en = rd_q && !(state == RD_U && bus.mem_rdata != 3'd0);
  assign cap           = rd_prev ? bus.mem_rdata : 3'd0;
  assign one_hot       = (bus.chk_tile_type != 6'd0) &&
                         ((bus.chk_tile_type & (bus.chk_tile_type - 6'd1)) == 6'd0);
  assign bad_pos       = ({1'b0, bus.req_row} >= ROWS_W) || ({1'b0, bus.req_col} >= COLS_W);

  always_comb begin
    low_code = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (bus.chk_tile_type[k]) low_code = 3'(k + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      rd_q           <= 1'b0;
      rd_prev        <= 1'b0;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wr_en  <= 1'b0;
      bus.mem_wdata  <= 3'd0;
      bus.chk_start  <= 1'b0;
      bus.chk_up     <= 3'd0;
      bus.chk_down   <= 3'd0;
      bus.chk_left   <= 3'd0;
      bus.chk_right  <= 3'd0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_tile   <= 3'd0;
      bus.rsp_status <= 3'd0;
    end else begin
      rd_prev       <= bus.mem_rd_en;
      bus.chk_start <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            row <= bus.req_row;
            col <= bus.req_col;
            if (bad_pos) begin
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_BADPOS;
              bus.rsp_tile   <= 3'd0;
              state          <= RESP;
            end else begin
              rd_q         <= 1'b1;
              bus.mem_addr <= {bus.req_row, bus.req_col};
              state        <= RD_C;
            end
          end
        end
        RD_C: begin
          rd_q <= (row != '0);
          if (row != '0) bus.mem_addr <= {row - 1'b1, col};
          state <= RD_U;
        end
        RD_U: begin
          if (bus.mem_rdata != 3'd0) begin
            rd_q           <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= ST_OCCUPIED;
            bus.rsp_tile   <= bus.mem_rdata;
            state          <= RESP;
          end else begin
            rd_q <= (row != ROW_LAST);
            if (row != ROW_LAST) bus.mem_addr <= {row + 1'b1, col};
            state <= RD_D;
          end
        end
        RD_D: begin
          bus.chk_up <= cap;
          rd_q <= (col != '0);
          if (col != '0) bus.mem_addr <= {row, col - 1'b1};
          state <= RD_L;
        end
        RD_L: begin
          bus.chk_down <= cap;
          rd_q <= (col != COL_LAST);
          if (col != COL_LAST) bus.mem_addr <= {row, col + 1'b1};
          state <= RD_R;
        end
        RD_R: begin
          bus.chk_left <= cap;
          rd_q  <= 1'b0;
          state <= CAP_R;
        end
        CAP_R: begin
          bus.chk_right <= cap;
          bus.chk_start <= 1'b1;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle is the chk_start cycle; the checker cannot answer yet.
          if (cnt != '0 && bus.chk_done) begin
            if (bus.chk_tile_type == 6'd0) begin
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_NONE;
              bus.rsp_tile   <= 3'd0;
              state          <= RESP;
            end else if (one_hot) begin
              bus.mem_wr_en <= 1'b1;
              bus.mem_addr  <= {row, col};
              bus.mem_wdata <= low_code;
              bus.rsp_tile  <= low_code;
              state         <= WRITE;
            end else begin
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_MULTI;
              bus.rsp_tile   <= low_code;
              state          <= RESP;
            end
          end else if (cnt >= CNT_LAST) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= ST_NONE;
            bus.rsp_tile   <= 3'd0;
            state          <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          bus.mem_wr_en  <= 1'b0;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_status <= ST_PLACED;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trax_tile_placer.sv
// tb/tb_trax_tile_placer.sv - directed scoreboard bench for trax_tile_placer with board RAM and checker models
module tb_trax_tile_placer;
  localparam int RB = 4;
  localparam int CB = 3;
  localparam int TO = 15;

  localparam int PLACED = 0, OCCUPIED = 1, MULTI = 2, NONE = 3, BADPOS = 4;

  typedef struct {
    int status;
    int tile;
    int lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  trax_tile_placer_if #(.ROW_BITS(RB), .COL_BITS(CB)) bus();

  trax_tile_placer #(
    .ROW_BITS(RB), .COL_BITS(CB), .ROWS(8), .COLS(8), .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   rd_log[$];
  int   wr_addr_log[$];
  int   wr_data_log[$];
  int   exp_rd_a[5] = '{27, 19, 35, 26, 28};
  int   exp_rd_b[3] = '{0, 8, 1};
  int   exp_rd_c[3] = '{63, 55, 62};

  logic [2:0] ram [0:127];
  logic       clr = 1'b0;
  logic       pre_en = 1'b0;
  logic [6:0] pre_addr = '0;
  logic [2:0] pre_data = '0;

  int         chk_dly = 1;
  logic [5:0] chk_mask = '0;
  logic [2:0] snap_u, snap_d, snap_l, snap_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Board RAM: one-cycle read latency, bench preload port takes priority over DUT writes.
  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 128; i++) ram[i] <= 3'd0;
    end else if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(negedge clock) begin
    if (bus.mem_rd_en) rd_log.push_back(int'(bus.mem_addr));
    if (bus.mem_wr_en) begin
      wr_addr_log.push_back(int'(bus.mem_addr));
      wr_data_log.push_back(int'(bus.mem_wdata));
    end
    if (bus.mem_rd_en || bus.mem_wr_en) chk("rd_wr_exclusive", 32'(bus.mem_rd_en && bus.mem_wr_en), 0);
  end

  initial begin
    bus.chk_done      = 1'b0;
    bus.chk_tile_type = 6'd0;
    forever begin
      @(negedge clock);
      if (bus.chk_start) begin
        snap_u = bus.chk_up;
        snap_d = bus.chk_down;
        snap_l = bus.chk_left;
        snap_r = bus.chk_right;
        if (chk_dly >= 1) begin
          repeat (chk_dly) @(posedge clock);
          #1;
          bus.chk_done      = 1'b1;
          bus.chk_tile_type = chk_mask;
          @(posedge clock);
          #1;
          bus.chk_done      = 1'b0;
          bus.chk_tile_type = 6'd0;
        end
      end
    end
  end

  task automatic preload(input int a, input int d);
    pre_addr = 7'(a);
    pre_data = 3'(d);
    pre_en   = 1'b1;
    @(posedge clock);
    #1 pre_en = 1'b0;
  endtask

  task automatic do_req(input int r, input int c, input int mask, input int dly,
                        input int st, input int tl, input int lat, input int hold);
    exp_t e;
    int   n;
    int   w;
    chk_mask = 6'(mask);
    chk_dly  = dly;
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    e.status = st;
    e.tile   = tl;
    e.lat    = lat;
    exp_q.push_back(e);
    w = 0;
    while (!bus.req_ready && w < 30) begin
      @(negedge clock);
      w++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_row   = RB'(r);
    bus.req_col   = CB'(c);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.rsp_valid && n < 60);
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 1);
    e = exp_q.pop_front();
    chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
    chk("rsp_tile", 32'(bus.rsp_tile), 32'(e.tile));
    chk("latency", 32'(n), 32'(e.lat));
    repeat (hold) begin
      @(negedge clock);
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_status", 32'(bus.rsp_status), 32'(e.status));
      chk("hold_tile", 32'(bus.rsp_tile), 32'(e.tile));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clock);
    chk("rsp_dropped", 32'(bus.rsp_valid), 0);
    chk("ready_after_rsp", 32'(bus.req_ready), 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.rsp_ready = 1'b0;
    clr = 1'b1;
    repeat (3) @(posedge clock);
    #1 clr = 1'b0;

    @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
    chk("rst_chk_start", 32'(bus.chk_start), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_rsp_status", 32'(bus.rsp_status), 0);
    chk("rst_chk_up", 32'(bus.chk_up), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("req_ready_rise", 32'(bus.req_ready), 1);

    // Empty board, centre cell, checker finds nothing.
    do_req(3, 3, 6'b000000, 1, NONE, 0, 9, 0);
    chk("none_rd_count", 32'(rd_log.size()), 5);
    if (rd_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("none_rd_addr", 32'(rd_log[i]), 32'(exp_rd_a[i]));
    chk("none_no_write", 32'(wr_addr_log.size()), 0);

    // Occupied centre stops after a single read.
    preload(27, 4);
    do_req(3, 3, 6'b000001, 1, OCCUPIED, 4, 3, 3);
    chk("occ_rd_count", 32'(rd_log.size()), 1);
    if (rd_log.size() == 1) chk("occ_rd_addr", 32'(rd_log[0]), 27);
    chk("occ_no_write", 32'(wr_addr_log.size()), 0);
    preload(27, 0);

    // Top-left corner: no up/left reads, forced tile 4 written.
    preload(1, 4);
    do_req(0, 0, 6'b001000, 1, PLACED, 4, 10, 0);
    chk("corner_rd_count", 32'(rd_log.size()), 3);
    if (rd_log.size() == 3)
      for (int i = 0; i < 3; i++) chk("corner_rd_addr", 32'(rd_log[i]), 32'(exp_rd_b[i]));
    chk("corner_chk_up", 32'(snap_u), 0);
    chk("corner_chk_left", 32'(snap_l), 0);
    chk("corner_chk_down", 32'(snap_d), 0);
    chk("corner_chk_right", 32'(snap_r), 4);
    chk("corner_wr_count", 32'(wr_addr_log.size()), 1);
    if (wr_addr_log.size() == 1) begin
      chk("corner_wr_addr", 32'(wr_addr_log[0]), 0);
      chk("corner_wr_data", 32'(wr_data_log[0]), 4);
    end

    // Several candidates: lowest reported, nothing written.
    do_req(2, 5, 6'b010010, 1, MULTI, 2, 9, 0);
    chk("multi_no_write", 32'(wr_addr_log.size()), 0);

    // Checker silent: NONE after exactly TIMEOUT cycles in WAIT (WAIT entered in cycle 7).
    do_req(5, 5, 6'b000000, -1, NONE, 0, 7 + TO, 0);
    chk("timeout_no_write", 32'(wr_addr_log.size()), 0);

    // Off-board row.
    do_req(8, 0, 6'b000001, 1, BADPOS, 0, 1, 0);
    chk("badpos_no_read", 32'(rd_log.size()), 0);

    // Bottom-right corner, accepted back-to-back after the previous response.
    do_req(7, 7, 6'b000001, 1, PLACED, 1, 10, 0);
    chk("br_rd_count", 32'(rd_log.size()), 3);
    if (rd_log.size() == 3)
      for (int i = 0; i < 3; i++) chk("br_rd_addr", 32'(rd_log[i]), 32'(exp_rd_c[i]));
    chk("br_wr_count", 32'(wr_addr_log.size()), 1);
    if (wr_addr_log.size() == 1) chk("br_wr_addr", 32'(wr_addr_log[0]), 63);

    // Reset while waiting on the checker.
    chk_dly = -1;
    wr_addr_log.delete();
    wr_data_log.delete();
    chk("abort_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_row   = RB'(6);
    bus.req_col   = CB'(2);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 0);
    chk("abort_chk_start", 32'(bus.chk_start), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready_rise", 32'(bus.req_ready), 1);
    repeat (20) @(negedge clock);
    chk("abort_rsp_quiet", 32'(bus.rsp_valid), 0);
    chk("abort_no_write", 32'(wr_addr_log.size()), 0);

    // Normal operation resumes after the abort.
    do_req(4, 4, 6'b100000, 1, PLACED, 6, 10, 0);
    chk("resume_wr_count", 32'(wr_addr_log.size()), 1);
    if (wr_data_log.size() == 1) chk("resume_wr_data", 32'(wr_data_log[0]), 6);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
